// File: rtl/ring_buf_ctl_if.sv
// Handshake bundle between a frame writer, a frame reader and the ring-buffer controller.
// master drives the requests and done pulses; slave is the controller itself.
interface ring_buf_ctl_if #(
    parameter int PTR_W = 2
);
    logic             start;
    logic             detach;
    logic             write_done;
    logic             read_done;
    logic [PTR_W-1:0] write_ptr;
    logic [PTR_W-1:0] read_ptr;
    logic             write_mode;
    logic             read_mode;
    logic [PTR_W:0]   level;
    logic             full;
    logic             empty;
    logic             buf_advanced;
    logic             stall;
    logic             running;
    logic             done;

    modport master (
        output start, detach, write_done, read_done,
        input  write_ptr, read_ptr, write_mode, read_mode, level,
               full, empty, buf_advanced, stall, running, done
    );

    modport slave (
        input  start, detach, write_done, read_done,
        output write_ptr, read_ptr, write_mode, read_mode, level,
               full, empty, buf_advanced, stall, running, done
    );
endinterface

// File: rtl/ring_buf_ctl.sv
// Ownership controller for NUM_BUFS shared frame buffers: a writer FSM fills buffers in ring
// order, a reader FSM drains them in the same order, and level tracks filled-but-unread buffers.
module ring_buf_ctl #(
    parameter int NUM_BUFS = 4,
    parameter int PTR_W    = 2
) (
    input logic           clk,
    input logic           reset_n,
    ring_buf_ctl_if.slave bus
);
    typedef enum logic { W_IDLE, W_FILL } w_state_t;
    typedef enum logic { R_IDLE, R_READ } r_state_t;

    localparam logic [PTR_W:0]   LEVEL_MAX = (PTR_W+1)'(NUM_BUFS);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_BUFS - 1);

    w_state_t         w_state;
    r_state_t         r_state;
    logic [PTR_W-1:0] write_ptr;
    logic [PTR_W-1:0] read_ptr;
    logic [PTR_W:0]   level;
    logic             pending;
    logic             running;
    logic             done;
    logic             buf_advanced;

    logic wr_accept;
    logic rd_accept;
    logic start_accept;
    logic w_enter;
    logic session_end;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Done pulses only count in the owning state; anything else is a stray pulse and is dropped.
    assign wr_accept    = (w_state == W_FILL) && bus.write_done;
    assign rd_accept    = (r_state == R_READ) && bus.read_done;
    assign start_accept = bus.start && !bus.detach && (w_state == W_IDLE) && !pending;
    // A fresh start counts as a request in its own cycle so the fill begins one cycle later.
    assign w_enter      = (w_state == W_IDLE) && (bus.detach || pending || bus.start)
                          && (level != LEVEL_MAX);
    assign session_end  = running && (w_state == W_IDLE) && (r_state == R_IDLE)
                          && (level == '0) && !pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state      <= W_IDLE;
            r_state      <= R_IDLE;
            write_ptr    <= '0;
            read_ptr     <= '0;
            level        <= '0;
            pending      <= 1'b0;
            running      <= 1'b0;
            done         <= 1'b0;
            buf_advanced <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all updates see the same pre-edge values.
            buf_advanced <= wr_accept;
            done         <= 1'b0;

            case (w_state)
                W_IDLE: begin
                    if (w_enter) begin
                        w_state <= W_FILL;
                        pending <= 1'b0;
                    end else if (start_accept) begin
                        pending <= 1'b1;
                    end
                end
                W_FILL: begin
                    if (bus.write_done) begin
                        w_state   <= W_IDLE;
                        write_ptr <= next_ptr(write_ptr);
                    end
                end
                default: w_state <= W_IDLE;
            endcase

            case (r_state)
                R_IDLE: if (level != '0) r_state <= R_READ;
                R_READ: begin
                    if (bus.read_done) begin
                        r_state  <= R_IDLE;
                        read_ptr <= next_ptr(read_ptr);
                    end
                end
                default: r_state <= R_IDLE;
            endcase

            case ({wr_accept, rd_accept})
                2'b10:   level <= level + (PTR_W+1)'(1);
                2'b01:   level <= level - (PTR_W+1)'(1);
                default: level <= level;
            endcase

            if (start_accept) begin
                running <= 1'b1;
            end else if (session_end) begin
                running <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

    assign bus.write_ptr    = write_ptr;
    assign bus.read_ptr     = read_ptr;
    assign bus.write_mode   = (w_state == W_FILL);
    assign bus.read_mode    = (r_state == R_READ);
    assign bus.level        = level;
    assign bus.full         = (level == LEVEL_MAX);
    assign bus.empty        = (level == '0);
    assign bus.buf_advanced = buf_advanced;
    assign bus.stall        = (w_state == W_IDLE) && (bus.detach || pending) && (level == LEVEL_MAX);
    assign bus.running      = running;
    assign bus.done         = done;
endmodule

// File: tb/tb_ring_buf_ctl.sv
// Directed bench for ring_buf_ctl: a four-buffer instance walks the attached, detached,
// collision, spurious-pulse and reset scenarios; a two-buffer instance runs randomised reads.
module tb_ring_buf_ctl;
    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    ring_buf_ctl_if #(.PTR_W(2)) bus_a ();
    ring_buf_ctl_if #(.PTR_W(1)) bus_b ();

    ring_buf_ctl #(.NUM_BUFS(4), .PTR_W(2)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    ring_buf_ctl #(.NUM_BUFS(2), .PTR_W(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_wptr"},  bus_a.write_ptr, 0);
        check({tag, "_rptr"},  bus_a.read_ptr, 0);
        check({tag, "_level"}, bus_a.level, 0);
        check({tag, "_empty"}, bus_a.empty, 1);
        check({tag, "_full"},  bus_a.full, 0);
        check({tag, "_wmode"}, bus_a.write_mode, 0);
        check({tag, "_rmode"}, bus_a.read_mode, 0);
        check({tag, "_adv"},   bus_a.buf_advanced, 0);
        check({tag, "_stall"}, bus_a.stall, 0);
        check({tag, "_run"},   bus_a.running, 0);
        check({tag, "_done"},  bus_a.done, 0);
    endtask

    initial begin
        logic       wexp;
        logic [0:0] q[$];
        int         reads;
        int         cycles;

        reset_n = 1'b0;
        {bus_a.start, bus_a.detach, bus_a.write_done, bus_a.read_done} = '0;
        {bus_b.start, bus_b.detach, bus_b.write_done, bus_b.read_done} = '0;
        #3;
        check_idle_a("por");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_idle_a("post_rst");

        // Attached single frame.
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("att_wmode", bus_a.write_mode, 1);
        check("att_run",   bus_a.running, 1);
        for (int i = 0; i < 9; i++) tick();
        check("att_wmode_held", bus_a.write_mode, 1);
        bus_a.write_done = 1'b1;
        tick();
        bus_a.write_done = 1'b0;
        check("att_level1", bus_a.level, 1);
        check("att_wptr1",  bus_a.write_ptr, 1);
        check("att_adv",    bus_a.buf_advanced, 1);
        check("att_wmode0", bus_a.write_mode, 0);
        tick();
        check("att_rmode",  bus_a.read_mode, 1);
        check("att_adv0",   bus_a.buf_advanced, 0);
        check("att_norefill", bus_a.write_mode, 0);
        bus_a.read_done = 1'b1;
        tick();
        bus_a.read_done = 1'b0;
        check("att_level0", bus_a.level, 0);
        check("att_rptr1",  bus_a.read_ptr, 1);
        check("att_run_hold", bus_a.running, 1);
        tick();
        check("att_run_fall", bus_a.running, 0);
        check("att_done",     bus_a.done, 1);
        tick();
        check("att_done_once", bus_a.done, 0);

        // Stray done pulses while both sides are idle.
        bus_a.write_done = 1'b1;
        bus_a.read_done  = 1'b1;
        tick();
        bus_a.write_done = 1'b0;
        bus_a.read_done  = 1'b0;
        check("spur_wptr",  bus_a.write_ptr, 1);
        check("spur_rptr",  bus_a.read_ptr, 1);
        check("spur_level", bus_a.level, 0);
        check("spur_modes", {bus_a.write_mode, bus_a.read_mode}, 0);
        check("spur_adv",   bus_a.buf_advanced, 0);
        check("spur_run",   {bus_a.running, bus_a.done}, 0);

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Detached writer filling a held reader until full.
        bus_a.detach = 1'b1;
        tick();
        check("det_wmode", bus_a.write_mode, 1);
        for (int i = 0; i < 4; i++) begin
            bus_a.write_done = 1'b1;
            tick();
            bus_a.write_done = 1'b0;
            if (i < 3) tick();
        end
        check("det_wrap",  bus_a.write_ptr, 0);
        check("det_full",  bus_a.full, 1);
        check("det_level", bus_a.level, 4);
        check("det_stall", bus_a.stall, 1);
        tick();
        check("det_wmode0", bus_a.write_mode, 0);
        check("det_stall_hold", bus_a.stall, 1);
        check("det_run0",  bus_a.running, 0);
        check("det_rown",  {bus_a.read_mode, bus_a.read_ptr}, {1'b1, 2'd0});
        bus_a.read_done = 1'b1;
        tick();
        bus_a.read_done = 1'b0;
        check("det_unstall", bus_a.stall, 0);
        check("det_level3",  bus_a.level, 3);
        tick();
        check("det_fill5", {bus_a.write_mode, bus_a.write_ptr}, {1'b1, 2'd0});
        check("det_read2", {bus_a.read_mode, bus_a.read_ptr}, {1'b1, 2'd1});

        // Dropping detach mid-fill must not abort the fill.
        bus_a.detach    = 1'b0;
        bus_a.read_done = 1'b1;
        tick();
        bus_a.read_done = 1'b0;
        check("detoff_wmode", bus_a.write_mode, 1);
        tick();
        check("both_pre", {bus_a.level, bus_a.write_ptr, bus_a.read_ptr}, {3'd2, 2'd0, 2'd2});
        bus_a.write_done = 1'b1;
        bus_a.read_done  = 1'b1;
        tick();
        bus_a.write_done = 1'b0;
        bus_a.read_done  = 1'b0;
        check("both_level", bus_a.level, 2);
        check("both_wptr",  bus_a.write_ptr, 1);
        check("both_rptr",  bus_a.read_ptr, 3);
        tick();
        check("detoff_idle", bus_a.write_mode, 0);

        // Reach W_FILL with level 3, then reset asynchronously mid-cycle.
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        bus_a.write_done = 1'b1;
        tick();
        bus_a.write_done = 1'b0;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("pre_rst", {bus_a.write_mode, bus_a.level}, {1'b1, 3'd3});
        bus_a.write_done = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_a("async_rst");
        tick();
        bus_a.write_done = 1'b0;
        reset_n = 1'b1;
        tick();
        check_idle_a("rst_after");

        // Two-buffer ring with a randomly paced reader.
        wexp   = 1'b0;
        reads  = 0;
        cycles = 0;
        bus_b.detach = 1'b1;
        while (reads < 100 && cycles < 5000) begin
            bus_b.write_done = bus_b.write_mode;
            bus_b.read_done  = bus_b.read_mode && ($urandom_range(0, 2) == 0);
            if (bus_b.write_done) begin
                check("b_wptr", bus_b.write_ptr, wexp);
                q.push_back(bus_b.write_ptr);
                wexp = ~wexp;
            end
            if (bus_b.read_done) begin
                if (q.size() == 0) check("b_read_underrun", q.size(), 1);
                else check("b_rptr", bus_b.read_ptr, q.pop_front());
                reads++;
            end
            tick();
            cycles++;
            check("b_level_le2", bus_b.level <= 2, 1);
        end
        bus_b.write_done = 1'b0;
        bus_b.read_done  = 1'b0;
        bus_b.detach     = 1'b0;
        check("b_reads", reads, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ring_buf_ctl.md
RING_BUF_CTL -- requirements
Module: ring_buf_ctl

Interface
REQ-001 Parameter NUM_BUFS, default 4, number of shared buffers in the ring, legal 2..16.
REQ-002 Parameter PTR_W, default 2, buffer-index width, SHALL equal clog2(NUM_BUFS).
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  one-cycle request to capture one frame (attached mode only).
REQ-006 Port detach  input  1  level: 1 = writer free-runs independent of start.
REQ-007 Port write_done  input  1  one-cycle pulse: writer finished current buffer.
REQ-008 Port read_done  input  1  one-cycle pulse: reader finished current buffer.
REQ-009 Port write_ptr  output  PTR_W  index of buffer owned by writer.
REQ-010 Port read_ptr  output  PTR_W  index of buffer owned by reader.
REQ-011 Port write_mode  output  1  writer may fill buffer write_ptr.
REQ-012 Port read_mode  output  1  reader may drain buffer read_ptr.
REQ-013 Port level  output  PTR_W+1  count of filled, unread buffers.
REQ-014 Port full / empty  output  1 each  level==NUM_BUFS / level==0.
REQ-015 Port buf_advanced  output  1  one-cycle pulse per accepted write_done.
REQ-016 Port stall  output  1  writer wants a buffer but ring is full.
REQ-017 Port running  output  1  attached-mode session active.
REQ-018 Port done  output  1  one-cycle pulse when running falls.

Function
REQ-019 Writer FSM states W_IDLE, W_FILL; write_mode SHALL be 1 exactly in W_FILL.
REQ-020 W_IDLE->W_FILL when (detach=1 or pending start) and level<NUM_BUFS; write_mode asserts the cycle after the condition.
REQ-021 Pending start: start accepted in W_IDLE with detach=0 sets a pending flag held until W_FILL entered; start while pending or in W_FILL ignored.
REQ-022 stall SHALL be 1 while in W_IDLE with entry request active and level==NUM_BUFS; cleared when a read_done frees a buffer.
REQ-023 In W_FILL, write_done -> W_IDLE, write_ptr increments modulo NUM_BUFS (NUM_BUFS-1 wraps to 0), buf_advanced pulses next cycle.
REQ-024 Reader FSM states R_IDLE, R_READ; read_mode SHALL be 1 exactly in R_READ.
REQ-025 R_IDLE->R_READ when level>0; read_mode asserts the cycle after; independent of detach.
REQ-026 In R_READ, read_done -> R_IDLE, read_ptr increments modulo NUM_BUFS.
REQ-027 level +1 on accepted write_done, -1 on accepted read_done, unchanged when both same cycle; never exceeds NUM_BUFS nor drops below 0.
REQ-028 write_done outside W_FILL and read_done outside R_READ SHALL be ignored (no state, pointer, level change).
REQ-029 write_ptr==read_ptr with level==0 or NUM_BUFS are the only legal equal-pointer states; reader never owns write_ptr buffer while write_mode=1.
REQ-030 running rises the cycle after an accepted start; falls when writer in W_IDLE, reader in R_IDLE, level==0, no pending start; done pulses that same cycle.
REQ-031 running SHALL stay 0 in detached operation; detach change takes effect only at next W_IDLE decision, never aborting W_FILL.

Reset
REQ-032 While reset_n=0: both FSMs idle, pointers 0, level 0, empty=1, full/write_mode/read_mode/buf_advanced/stall/running/done 0, pending cleared.
REQ-033 Reset asserted mid-frame SHALL abandon buffer contents and discard in-flight done pulses; first post-reset cycle behaves as power-up.

Verification
REQ-034 NUM_BUFS=4, detach=0, start then write_done after 10 cycles -> write_mode 1 cycle after start, level 1, write_ptr 1, read_mode next cycle; read_done -> level 0, running falls, done pulses once.
REQ-035 detach=1, reader held (no read_done) -> four fills, write_ptr wraps to 0, full=1, stall=1, write_mode 0; one read_done -> stall 0, fifth fill starts on buffer 0.
REQ-036 level=2, write_done and read_done same cycle -> level stays 2, both pointers advance by 1.
REQ-037 Spurious write_done in W_IDLE and read_done in R_IDLE -> no change to any output.
REQ-038 reset_n pulsed low during W_FILL with level=3 -> all outputs at reset values immediately, asynchronous.
REQ-039 NUM_BUFS=2, PTR_W=1, random read_done timing over 100 frames -> level never above 2, pointer sequence 0,1,0,1, reads equal writes in order.
